// File: rtl/fifo8_delay_drain.sv
// fifo8_delay_drain
// Programmable sample delay line with end-of-burst drain. Accepted input
// samples are written into a 64-entry ring buffer. Once the latched delay
// is filled, every accepted sample reads out the sample from d_lat accepted
// beats earlier. A beat flagged last moves the block to DRAIN. DRAIN flushes
// every stored sample, and the final flushed sample is marked with
// data_out_last.
//
// Ports
//   clk            : single clock
//   rstn           : synchronous active-low reset
//   delay_ctl      : requested delay, clamped to 63, latched on FILL entry
//   data_in        : input sample
//   data_in_valid  : qualifies data_in
//   data_in_last   : end of burst (only meaningful with data_in_valid)
//   data_out       : delayed sample, registered; holds while not valid
//   data_out_valid : qualifies data_out
//   data_out_last  : final sample of a drain
//   busy           : high in IDLE and DRAIN, where input is not accepted
//   drop           : one-cycle pulse after each discarded input beat
module fifo8_delay_drain #(
  parameter int DATA_WIDTH      = 8,
  parameter int DELAY_CTL_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DELAY_CTL_WIDTH-1:0] delay_ctl,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       data_in_valid,
  input  logic                       data_in_last,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_out_valid,
  output logic                       data_out_last,
  output logic                       busy,
  output logic                       drop
);

  localparam int DEPTH = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t                r_state;
  logic [2:0]            r_idle_cnt;
  logic [5:0]            r_wp;
  logic [5:0]            r_rp;
  logic [6:0]            r_occ;
  logic [5:0]            r_d_lat;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic [5:0]            w_d_req;
  logic                  w_accept;
  logic                  w_rd_beat;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Requested delay clamped to the largest delay the ring can hold.
  always_comb begin
    w_d_req = delay_ctl[5:0];
    if (delay_ctl > DELAY_CTL_WIDTH'(DEPTH - 1)) begin
      w_d_req = 6'(DEPTH - 1);
    end
  end

  // A beat is accepted only in FILL/RUN. An accepted beat also reads once
  // the buffer already holds d_lat samples.
  always_comb begin
    w_accept  = data_in_valid && ((r_state == S_FILL) || (r_state == S_RUN));
    w_rd_beat = w_accept && (r_occ == {1'b0, r_d_lat});
  end

  // With an empty buffer (d_lat = 0) the sample being written is the
  // oldest one. It is forwarded directly because the RAM write has not
  // landed yet.
  always_comb begin
    w_rd_data = r_mem[r_rp];
    if (r_occ == 7'd0) begin
      w_rd_data = data_in;
    end
  end

  // Sample storage. It is not reset, because its contents are discarded
  // on reset anyway.
  always_ff @(posedge clk) begin
    if (rstn && w_accept) begin
      r_mem[r_wp] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_idle_cnt     <= '0;
      r_wp           <= '0;
      r_rp           <= '0;
      r_occ          <= '0;
      r_d_lat        <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      busy           <= 1'b1;
      drop           <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      drop           <= 1'b0;

      case (r_state)
        S_IDLE: begin
          drop       <= data_in_valid;
          r_idle_cnt <= r_idle_cnt + 3'd1;
          if (r_idle_cnt == 3'd7) begin
            r_state <= S_FILL;
            r_d_lat <= w_d_req;
            busy    <= 1'b0;
          end
        end

        S_FILL, S_RUN: begin
          if (data_in_valid) begin
            r_wp <= r_wp + 6'd1;
            if (w_rd_beat) begin
              r_rp           <= r_rp + 6'd1;
              data_out       <= w_rd_data;
              data_out_valid <= 1'b1;
            end else begin
              r_occ <= r_occ + 7'd1;
            end

            if (data_in_last) begin
              // A read beat on an empty buffer leaves nothing to drain.
              // That beat carries the last flag, and DRAIN is skipped.
              if (w_rd_beat && (r_occ == 7'd0)) begin
                data_out_last <= 1'b1;
                r_state       <= S_FILL;
                r_d_lat       <= w_d_req;
              end else begin
                r_state <= S_DRAIN;
                busy    <= 1'b1;
              end
            end else if (w_rd_beat) begin
              r_state <= S_RUN;
            end
          end
        end

        S_DRAIN: begin
          drop           <= data_in_valid;
          data_out       <= r_mem[r_rp];
          data_out_valid <= 1'b1;
          r_rp           <= r_rp + 6'd1;
          r_occ          <= r_occ - 7'd1;
          if (r_occ == 7'd1) begin
            data_out_last <= 1'b1;
            r_state       <= S_FILL;
            r_d_lat       <= w_d_req;
            busy          <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo8_delay_drain.sv
// Testbench for fifo8_delay_drain. A queue-based reference model is checked
// against the DUT on every cycle. Directed bursts are additionally pinned
// to hand-computed output sequences. A randomized phase follows.
module tb_fifo8_delay_drain;

  localparam int DW = 8;
  localparam int CW = 7;

  localparam int M_IDLE  = 0;
  localparam int M_ACC   = 1;
  localparam int M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [CW-1:0] delay_ctl = '0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          data_in_last = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_last;
  logic          busy;
  logic          drop;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fifo8_delay_drain #(
    .DATA_WIDTH     (DW),
    .DELAY_CTL_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .delay_ctl     (delay_ctl),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_last  (data_in_last),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_last (data_out_last),
    .busy          (busy),
    .drop          (drop)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model. Stored samples are kept in a queue. The model tracks
  // only three phases: idle countdown, accepting, and draining.
  logic [DW-1:0] mq[$];
  int            m_mode = M_IDLE;
  int            m_idle = 0;
  int            m_dl   = 0;
  logic [DW-1:0] e_out  = '0;
  logic          e_v = 1'b0, e_l = 1'b0, e_busy = 1'b1, e_drop = 1'b0;

  function automatic int clamp(input logic [CW-1:0] d);
    return (int'(d) > 63) ? 63 : int'(d);
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      m_mode = M_IDLE; m_idle = 0; m_dl = 0;
      e_out = '0; e_v = 1'b0; e_l = 1'b0; e_drop = 1'b0;
    end else begin
      e_v = 1'b0; e_l = 1'b0; e_drop = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (data_in_valid) e_drop = 1'b1;
          m_idle++;
          if (m_idle == 8) begin m_mode = M_ACC; m_dl = clamp(delay_ctl); end
        end
        M_ACC: begin
          if (data_in_valid) begin
            mq.push_back(data_in);
            if (mq.size() > m_dl) begin e_out = mq.pop_front(); e_v = 1'b1; end
            if (data_in_last) begin
              if (mq.size() == 0) begin e_l = 1'b1; m_dl = clamp(delay_ctl); end
              else m_mode = M_DRAIN;
            end
          end
        end
        default: begin
          if (data_in_valid) e_drop = 1'b1;
          e_out = mq.pop_front(); e_v = 1'b1;
          if (mq.size() == 0) begin e_l = 1'b1; m_mode = M_ACC; m_dl = clamp(delay_ctl); end
        end
      endcase
    end
    e_busy = (m_mode != M_ACC);
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("drop", 32'(drop), 32'(e_drop));
    chk("out_valid", 32'(data_out_valid), 32'(e_v));
    chk("out_last", 32'(data_out_last), 32'(e_l));
    chk("data_out", 32'(data_out), 32'(e_out));
  end

  // Capture of DUT output beats for the literal checks of directed tests.
  logic [DW:0] cap[$];
  int          n_drop = 0;
  always @(posedge clk) begin
    #2;
    if (data_out_valid === 1'b1) cap.push_back({data_out_last, data_out});
    if (drop === 1'b1) n_drop++;
  end

  logic [DW:0] exp_cap[$];

  // Expected outputs: count values starting at first, each step apart,
  // with last on the final one.
  task automatic build_exp(input int count, input int first, input int step);
    exp_cap.delete();
    for (int i = 0; i < count; i++)
      exp_cap.push_back({(i == count - 1), DW'(first + i * step)});
  endtask

  task automatic check_cap(input string name);
    int n;
    chk({name, "_count"}, 32'(cap.size()), 32'(exp_cap.size()));
    n = (cap.size() < exp_cap.size()) ? cap.size() : exp_cap.size();
    for (int i = 0; i < n; i++) chk({name, "_beat"}, 32'(cap[i]), 32'(exp_cap[i]));
  endtask

  task automatic release_and_count();
    int n;
    rstn = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    chk("idle_cycles", 32'(n), 32'd8);
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rstn = 1'b0; data_in_valid = 1'b0; data_in_last = 1'b0; delay_ctl = CW'(d);
    @(negedge clk);
    @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(data_out_valid), 32'd0);
    chk("rst_last", 32'(data_out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_drop", 32'(drop), 32'd0);
    release_and_count();
  endtask

  task automatic burst(input int count, input int first, input int step, input int gap);
    for (int i = 0; i < count; i++) begin
      data_in_valid = 1'b1;
      data_in       = DW'(first + i * step);
      data_in_last  = (i == count - 1);
      @(negedge clk);
      data_in_valid = 1'b0;
      data_in_last  = 1'b0;
      for (int g = 0; g < gap; g++) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Delay 4, values 1..10, last on 10.
    do_reset(4);
    cap.delete();
    burst(10, 1, 1, 0);
    idle(20);
    build_exp(10, 1, 1);
    check_cap("d4");

    // Delay 0: pass-through, last on 0x33, no drain.
    do_reset(0);
    cap.delete();
    burst(3, 8'h11, 8'h11, 0);
    chk("d0_busy_after", 32'(busy), 32'd0);
    idle(5);
    build_exp(3, 8'h11, 8'h11);
    check_cap("d0");

    // Delay 63 with 5 beats: everything comes from the drain.
    do_reset(63);
    cap.delete();
    burst(5, 1, 1, 0);
    chk("d63_no_fill_out", 32'(cap.size()), 32'd0);
    idle(20);
    build_exp(5, 1, 1);
    check_cap("d63");

    // Clamped delay with input held valid during the drain.
    do_reset(100);
    cap.delete();
    n_drop = 0;
    burst(70, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      data_in_valid = 1'b1; data_in = DW'($urandom); data_in_last = 1'($urandom);
      @(negedge clk);
    end
    data_in_valid = 1'b0; data_in_last = 1'b0;
    idle(100);
    chk("clamp_drops", 32'(n_drop), 32'd10);
    build_exp(70, 1, 1);
    check_cap("clamp");

    // Reset while 3 samples are still waiting in the drain.
    do_reset(4);
    cap.delete();
    burst(6, 8'h40, 1, 0);
    @(negedge clk);
    delay_ctl = CW'(2);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(data_out_valid), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    release_and_count();
    build_exp(3, 8'h40, 1);
    exp_cap[2] = {1'b0, 8'h42};
    check_cap("pre_rst");
    cap.delete();
    burst(5, 8'h80, 1, 0);
    idle(10);
    build_exp(5, 8'h80, 1);
    check_cap("d2_after_rst");

    // Gapped input at delay 3.
    do_reset(3);
    cap.delete();
    burst(10, 1, 1, 1);
    idle(10);
    build_exp(10, 1, 1);
    check_cap("gapped");

    // Randomized traffic, delay changes and occasional resets.
    do_reset($urandom_range(0, 8));
    for (int c = 0; c < 4000; c++) begin
      rstn          = ($urandom_range(0, 499) != 0);
      data_in_valid = ($urandom_range(0, 2) != 0);
      data_in_last  = ($urandom_range(0, 19) == 0);
      data_in       = DW'($urandom);
      if ($urandom_range(0, 49) == 0)
        delay_ctl = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 127)) : CW'($urandom_range(0, 8));
      @(negedge clk);
    end
    rstn = 1'b1;
    data_in_valid = 1'b0;
    data_in_last = 1'b0;
    idle(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
